gpu_draw_scheduler: RTL and testbench
=====================================

// Module: gpu_draw_scheduler
// PURPOSE
//  Buffers decoded draw instructions from gpu_instruction_decoder in a FIFO and dispatches them one at a
//  time to the line or circle rasterizer engine with a start/done handshake. Sits between decoder and
//  rasterizers; serializes shared operand buses, detects overflow/illegal ops, aborts hung engines.
// PARAMETERS
//  DEPTH      4'd8      FIFO entries; power of 2, >=2
//  TIMEOUT    16'd1024  max WAIT cycles before abort, >=2
//  OP_LINE    4'h4      opcode routed to line engine
//  OP_CIRCLE  4'h5      opcode routed to circle engine
// PORTS
//  clk             in   1                 system clock, rising edge
//  n_rst           in   1                 asynchronous active-low reset
//  push_i          in   1                 enqueue instruction this cycle (decoder push_instruction_o)
//  opcode_i        in   4                 instruction opcode
//  x1_i/x2_i       in   `WIDTH_BITS       endpoint X; rad_i same width
//  y1_i/y2_i       in   `HEIGHT_BITS      endpoint Y
//  r_i/g_i/b_i     in   `CHANNEL_BITS     colour
//  line_done_i     in   1                 1-cycle pulse: line engine finished
//  circle_done_i   in   1                 1-cycle pulse: circle engine finished
//  line_start_o    out  1                 1-cycle start to line engine
//  circle_start_o  out  1                 1-cycle start to circle engine
//  x1_o..b_o       out  as inputs         operands of issued instruction (shared bus)
//  count_o         out  $clog2(DEPTH)+1   FIFO occupancy
//  full_o/empty_o  out  1                 FIFO status
//  busy_o          out  1                 state!=IDLE or !empty_o
//  illegal_o       out  1                 1-cycle pulse: unknown opcode discarded
//  abort_o         out  1                 1-cycle pulse: engine timed out
//  overflow_o      out  1                 sticky: push dropped while full
// BEHAVIOUR
//  Reset (async, n_rst=0): FIFO empty, count_o=0, state=IDLE, all operand regs/outputs 0, empty_o=1,
//   all pulses and overflow_o 0. Reset mid-operation discards queue and in-flight op; a done pulse
//   arriving after reset is ignored.
//  FIFO: entry={opcode,x1,y1,x2,y2,rad,r,g,b}; push sampled on rising edge, visible next cycle (no bypass).
//   Push while full: dropped, overflow_o<=1 until reset; EXCEPTION: push+pop same edge while full accepted.
//   Pointers wrap modulo DEPTH; count_o = pushes-pops accepted.
//  FSM (state registered):
//   IDLE  : if !empty -> pop head into command reg, ->ISSUE. else stay.
//   ISSUE : opcode==OP_LINE -> line_start_o=1; ==OP_CIRCLE -> circle_start_o=1; ->WAIT, timer=0.
//           other opcode: no start, illegal_o=1 this cycle, ->IDLE.
//           done inputs ignored in ISSUE.
//   WAIT  : only done of the engine that was started is honoured; done -> IDLE.
//           else timer++; when timer==TIMEOUT-1 at edge -> IDLE, abort_o=1 in the following cycle.
//           done in same cycle as timeout wins (no abort).
//  Starts/illegal_o are Moore outputs decoded from state+command reg: exactly one cycle wide.
//  Latency: push at edge k -> start high during cycle after edge k+1 (2 edges).
//   Min gap between ops: done at edge e -> IDLE, pop at e+1, next start after e+1.
//  Operand outputs held stable from ISSUE until leaving WAIT; change only on pop.
//  overflow_o independent of FSM; busy_o combinational.
// TESTING (DEPTH=4, TIMEOUT=16)
//  1 Reset: assert n_rst=0 mid-cycle -> all outputs 0, empty_o=1, count_o=0 immediately.
//  2 push op 4 x1=0 y1=0 x2=7 y2=3 rgb=5/A/F -> line_start_o 1 cycle, 2 edges after push, operands match;
//    line_done_i 5 cycles later -> IDLE, busy_o=0.
//  3 Engine stalled, 6 back-to-back pushes -> 1 in flight + 4 queued, 6th dropped, overflow_o=1, full_o=1.
//  4 Queue {4, 1, 5} -> line issued; op 1 gives illegal_o pulse, no start; op 5 then circle_start_o.
//  5 op 5, circle_done_i never -> abort_o pulse after 16 WAIT cycles; next queued op 4 issued;
//    line_done_i pulsed during circle WAIT ignored.
//  6 3 ops queued, n_rst=0 during WAIT -> count_o=0, no start; line_done_i after release ignored.

Source files
------------

// File: rtl/gpu_draw_scheduler.sv
// gpu_draw_scheduler: FIFO-buffered dispatcher of draw ops to the line/circle rasterizers with hung-engine abort
module gpu_draw_scheduler #(
  parameter int         DEPTH        = 8,
  parameter int         TIMEOUT      = 1024,
  parameter logic [3:0] OP_LINE      = 4'h4,
  parameter logic [3:0] OP_CIRCLE    = 4'h5,
  parameter int         WIDTH_BITS   = 10,
  parameter int         HEIGHT_BITS  = 9,
  parameter int         CHANNEL_BITS = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      push_i,
  input  logic [3:0]                opcode_i,
  input  logic [WIDTH_BITS-1:0]     x1_i,
  input  logic [HEIGHT_BITS-1:0]    y1_i,
  input  logic [WIDTH_BITS-1:0]     x2_i,
  input  logic [HEIGHT_BITS-1:0]    y2_i,
  input  logic [WIDTH_BITS-1:0]     rad_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  input  logic                      line_done_i,
  input  logic                      circle_done_i,
  output logic                      line_start_o,
  output logic                      circle_start_o,
  output logic [WIDTH_BITS-1:0]     x1_o,
  output logic [HEIGHT_BITS-1:0]    y1_o,
  output logic [WIDTH_BITS-1:0]     x2_o,
  output logic [HEIGHT_BITS-1:0]    y2_o,
  output logic [WIDTH_BITS-1:0]     rad_o,
  output logic [CHANNEL_BITS-1:0]   r_o,
  output logic [CHANNEL_BITS-1:0]   g_o,
  output logic [CHANNEL_BITS-1:0]   b_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      busy_o,
  output logic                      illegal_o,
  output logic                      abort_o,
  output logic                      overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + 3*WIDTH_BITS + 2*HEIGHT_BITS + 3*CHANNEL_BITS;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        r_state, w_next;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_cmd;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [15:0]   r_timer;
  logic          r_abort, r_ovf;
  logic          w_pop, w_push, w_done, w_timeout, w_line, w_circle;
  logic [3:0]    w_op;
  assign w_op      = r_cmd[EW-1 -: 4];
  assign w_line    = w_op == OP_LINE;
  assign w_circle  = w_op == OP_CIRCLE;
  assign full_o    = r_count[AW];
  assign empty_o   = r_count == '0;
  assign w_pop     = r_state == IDLE && !empty_o;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign w_push    = push_i && (!full_o || w_pop);
  assign w_done    = w_line ? line_done_i : circle_done_i;
  assign w_timeout = r_state == WAIT && !w_done && r_timer == T_LAST;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_cmd   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_pop) r_cmd <= r_mem[r_rd];
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= r_ovf | (push_i && !w_push);
    end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= r_state == WAIT ? r_timer + 1'b1 : '0;
      r_abort <= w_timeout;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = empty_o ? IDLE : ISSUE;
      ISSUE:   w_next = (w_line || w_circle) ? WAIT : IDLE;
      WAIT:    w_next = (w_done || w_timeout) ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  assign line_start_o   = r_state == ISSUE && w_line;
  assign circle_start_o = r_state == ISSUE && w_circle;
  assign illegal_o      = r_state == ISSUE && !w_line && !w_circle;
  assign abort_o        = r_abort;
  assign overflow_o     = r_ovf;
  assign busy_o         = r_state != IDLE || !empty_o;
  assign count_o        = r_count;
  assign {x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o} = r_cmd[EW-5:0];
endmodule

// File: tb/tb_gpu_draw_scheduler.sv
// tb_gpu_draw_scheduler: vector table, directed corner sequences and random traffic against a queue-based model
module tb_gpu_draw_scheduler;
  localparam int DEPTH = 4, TIMEOUT = 16, WB = 10, HB = 9, CB = 4;
  logic clk = 1'b0, n_rst, push_i = 1'b0, line_done_i = 1'b0, circle_done_i = 1'b0;
  logic [3:0] opcode_i = '0;
  logic [WB-1:0] x1_i = '0, x2_i = '0, rad_i = '0, x1_o, x2_o, rad_o;
  logic [HB-1:0] y1_i = '0, y2_i = '0, y1_o, y2_o;
  logic [CB-1:0] r_i = '0, g_i = '0, b_i = '0, r_o, g_o, b_o;
  logic line_start_o, circle_start_o, full_o, empty_o, busy_o, illegal_o, abort_o, overflow_o;
  logic [2:0] count_o;
  int vectors = 0, miscompares = 0;

  gpu_draw_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) dut (
    .clk(clk), .n_rst(n_rst), .push_i(push_i), .opcode_i(opcode_i),
    .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i), .rad_i(rad_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .line_done_i(line_done_i), .circle_done_i(circle_done_i),
    .line_start_o(line_start_o), .circle_start_o(circle_start_o),
    .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o), .rad_o(rad_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .busy_o(busy_o), .illegal_o(illegal_o), .abort_o(abort_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op; logic [WB-1:0] x1; logic [HB-1:0] y1; logic [WB-1:0] x2; logic [HB-1:0] y2;
    logic [WB-1:0] rad; logic [CB-1:0] r; logic [CB-1:0] g; logic [CB-1:0] b;
  } ins_t;

  // model: a plain queue plus the instruction in flight and the edge number at which it times out
  ins_t q[$];
  ins_t m_cmd;
  int m_ph, edge_no, m_deadline;
  bit m_abort, m_ovf;

  task automatic model_reset();
    q.delete();
    m_cmd = '0; m_ph = 0; m_abort = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    int sz; bit pop; ins_t in;
    sz = q.size();
    pop = m_ph == 0 && sz > 0;
    in = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i};
    m_abort = 0;
    edge_no++;
    case (m_ph)
      0: if (pop) begin m_cmd = q.pop_front(); m_ph = 1; end
      1: if (m_cmd.op == 4'h4 || m_cmd.op == 4'h5) begin m_ph = 2; m_deadline = edge_no + TIMEOUT; end
         else m_ph = 0;
      default:
        if ((m_cmd.op == 4'h4) ? line_done_i : circle_done_i) m_ph = 0;
        else if (edge_no == m_deadline) begin m_ph = 0; m_abort = 1; end
    endcase
    if (push_i) begin
      if (sz < DEPTH || pop) q.push_back(in);
      else m_ovf = 1;
    end
  endtask

  function automatic logic [10:0] dut_status();
    return {line_start_o, circle_start_o, illegal_o, abort_o, overflow_o, full_o, empty_o, busy_o, count_o};
  endfunction

  function automatic logic [59:0] dut_ops();
    return {x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    bit issue, lt, ct;
    issue = m_ph == 1;
    lt = m_cmd.op == 4'h4;
    ct = m_cmd.op == 4'h5;
    chk("model_status", 64'(dut_status()),
        64'({issue && lt, issue && ct, issue && !lt && !ct, m_abort, m_ovf,
             q.size() == DEPTH, q.size() == 0, m_ph != 0 || q.size() > 0, 3'(q.size())}));
    chk("model_operands", 64'(dut_ops()),
        64'({m_cmd.x1, m_cmd.y1, m_cmd.x2, m_cmd.y2, m_cmd.rad, m_cmd.r, m_cmd.g, m_cmd.b}));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic mid_reset();
    #3 n_rst = 1'b0;
    model_reset();
    #1;
    chk("reset_status", 64'(dut_status()), 64'(11'h010));
    chk("reset_operands", 64'(dut_ops()), 64'd0);
    cmp_model();
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  typedef struct {
    logic push; logic [3:0] op; logic ld, cd;
    logic ls, cs, ill; logic [2:0] cnt; logic busy;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t v(int p, int op, int ld, int cd, int ls, int cs, int il, int cnt, int bz);
    vec_t r;
    r.push = p != 0; r.op = 4'(op); r.ld = ld != 0; r.cd = cd != 0;
    r.ls = ls != 0; r.cs = cs != 0; r.ill = il != 0; r.cnt = 3'(cnt); r.busy = bz != 0;
    return r;
  endfunction

  initial begin
    tbl[0]  = v(1, 4, 0, 0, 0, 0, 0, 1, 1);
    tbl[1]  = v(0, 4, 0, 0, 1, 0, 0, 0, 1);
    tbl[2]  = v(0, 4, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = v(0, 4, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = v(0, 4, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = v(0, 4, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = v(0, 4, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(1, 4, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = v(1, 1, 0, 0, 1, 0, 0, 1, 1);
    tbl[9]  = v(1, 5, 0, 0, 0, 0, 0, 2, 1);
    tbl[10] = v(0, 0, 1, 0, 0, 0, 0, 2, 1);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[13] = v(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = v(0, 0, 0, 1, 0, 0, 0, 0, 0);
    edge_no = 0;
    model_reset();
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("por_status", 64'(dut_status()), 64'(11'h010));
    n_rst = 1'b1;

    // single line op, then the {4,1,5} mix
    x1_i = 10'd0; y1_i = 9'd0; x2_i = 10'd7; y2_i = 9'd3; r_i = 4'h5; g_i = 4'hA; b_i = 4'hF;
    for (int i = 0; i < 16; i++) begin
      push_i = tbl[i].push; opcode_i = tbl[i].op; line_done_i = tbl[i].ld; circle_done_i = tbl[i].cd;
      tick();
      chk($sformatf("tbl_row%0d", i), 64'({line_start_o, circle_start_o, illegal_o, count_o, busy_o}),
          64'({tbl[i].ls, tbl[i].cs, tbl[i].ill, tbl[i].cnt, tbl[i].busy}));
      if (i == 1) chk("t2_operands", 64'(dut_ops()), 64'({10'd0, 9'd0, 10'd7, 9'd3, 10'd0, 4'h5, 4'hA, 4'hF}));
    end
    push_i = 0; line_done_i = 0; circle_done_i = 0;

    // stalled engine: six pushes, the sixth is dropped
    push_i = 1; opcode_i = 4'h4;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) chk("full_no_ovf", 64'({full_o, overflow_o}), 64'(2'b10));
    end
    push_i = 0;
    chk("ovf_state", 64'({full_o, overflow_o, count_o}), 64'({1'b1, 1'b1, 3'd4}));
    mid_reset();

    // circle hangs, line done during its wait is ignored, then the queued line issues
    push_i = 1; opcode_i = 4'h5; tick();
    opcode_i = 4'h4; tick();
    push_i = 0;
    chk("circle_start", 64'(circle_start_o), 64'd1);
    for (int j = 0; j < 16; j++) begin
      line_done_i = j == 3;
      tick();
      chk($sformatf("no_abort%0d", j), 64'({abort_o, busy_o}), 64'(2'b01));
    end
    line_done_i = 0;
    tick();
    chk("abort_pulse", 64'({abort_o, count_o}), 64'({1'b1, 3'd1}));
    tick();
    chk("line_after_abort", 64'({line_start_o, abort_o}), 64'(2'b10));
    tick();
    line_done_i = 1; tick(); line_done_i = 0;
    chk("idle_after_line", 64'(busy_o), 64'd0);

    // reset during WAIT with three queued ops; a late done is ignored
    push_i = 1; opcode_i = 4'h4;
    for (int i = 0; i < 4; i++) tick();
    push_i = 0;
    chk("queued3", 64'(count_o), 64'd3);
    mid_reset();
    line_done_i = 1; tick(); line_done_i = 0;
    chk("late_done", 64'({line_start_o, busy_o, count_o}), 64'd0);
    tick();
    chk("stay_idle", 64'({line_start_o, busy_o}), 64'd0);

    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      push_i = $urandom_range(0, 1) == 1;
      opcode_i = sel < 2 ? 4'h4 : sel < 4 ? 4'h5 : 4'($urandom);
      x1_i = WB'($urandom); y1_i = HB'($urandom); x2_i = WB'($urandom); y2_i = HB'($urandom);
      rad_i = WB'($urandom); r_i = CB'($urandom); g_i = CB'($urandom); b_i = CB'($urandom);
      line_done_i = $urandom_range(0, 9) == 0;
      circle_done_i = $urandom_range(0, 9) == 0;
      tick();
    end
    push_i = 0; line_done_i = 0; circle_done_i = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
